// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and bit timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int TICKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Small FIFO: 2^FIFO_W entries, extra pointer bit separates full/empty.
// Ports: clk, reset, wr, rd, w_data, r_data (show-ahead), full, empty.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int FIFO_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              full,
    output logic              empty
);

    localparam logic [FIFO_W:0] PTR_ONE = {{FIFO_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [2**FIFO_W];
    logic [FIFO_W:0]   w_ptr;
    logic [FIFO_W:0]   r_ptr;
    logic              wr_en;
    logic              rd_en;

    // A write while full is dropped, even if a pop happens in the same cycle.
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[FIFO_W] != r_ptr[FIFO_W]) &&
                   (w_ptr[FIFO_W-1:0] == r_ptr[FIFO_W-1:0]);

    assign r_data = mem[r_ptr[FIFO_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr[FIFO_W-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_en) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_en) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter with parity bit and transmit FIFO.
// Ports: clk, reset, s_tick (16x baud), wr/din (FIFO push), tx, tx_full, tx_done_tick.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int FIFO_W     = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_full,
    output logic       tx_done_tick
);

    localparam logic [3:0] BIT_LAST  = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    uart_state_e state_q, state_d;
    logic [3:0]  s_q, s_d;
    logic [2:0]  n_q, n_d;
    logic [7:0]  b_q, b_d;
    logic        p_q, p_d;
    logic        tx_q, tx_d;

    logic        fifo_rd;
    logic        fifo_empty;
    logic [7:0]  fifo_data;

    uart_fifo #(
        .DATA_W(8),
        .FIFO_W(FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .rd    (fifo_rd),
        .w_data(din),
        .r_data(fifo_data),
        .full  (tx_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d follows the current state, so the line lags the FSM by one clock.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        p_d          = p_q;
        tx_d         = 1'b1;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    b_d     = fifo_data;
                    s_d     = '0;
                    p_d     = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                tx_d = b_q[0];
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        p_d = p_q ^ b_q[0];
                        if (n_q == N_LAST) begin
                            state_d = PARITY;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                tx_d = p_q ^ ODD;
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx = tx_q;

endmodule

// File: doc/uart_tx_parity.md
UART_TX_PARITY -- requirements
Module: uart_tx_parity

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16, giving the number of s_tick pulses in the stop bit.
REQ-003 The block SHALL have parameter FIFO_W, default 2, giving the transmit FIFO depth as 2^FIFO_W entries.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-005 Port clk SHALL be an input, 1 bit wide: the single system clock, rising-edge active.
REQ-006 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-007 Port s_tick SHALL be an input, 1 bit wide: a one-clock pulse at 16x the baud rate.
REQ-008 Port wr SHALL be an input, 1 bit wide: a write strobe that pushes din into the FIFO.
REQ-009 Port din SHALL be an input, 8 bits wide: the byte to transmit.
REQ-010 Port tx SHALL be an output, 1 bit wide: the registered serial line, idle high.
REQ-011 Port tx_full SHALL be an output, 1 bit wide: asserted while the FIFO is full.
REQ-012 Port tx_done_tick SHALL be an output, 1 bit wide: a one-clock pulse at the end of each frame.

Function
REQ-013 Frame format SHALL be: start bit 0, then DBIT data bits LSB first, then one parity bit, then the stop bit 1.
REQ-014 The parity bit SHALL equal the XOR of the transmitted data bits, XOR PARITY_ODD.
REQ-015 The start, data and parity bits SHALL each last exactly 16 s_tick pulses; the stop bit SHALL last SB_TICK pulses.
REQ-016 The FSM SHALL have states idle, start, data, parity and stop, with tick counter s (4 bits), bit counter n (3 bits), shift register b (8 bits) and parity accumulator p.
REQ-017 In idle with the FIFO not empty, the FSM SHALL pop one entry, load b, clear s and p, and enter start on the same clock edge.
REQ-018 In start, on s_tick with s==15, the FSM SHALL clear s and n and enter data.
REQ-019 In data, on s_tick with s==15, the FSM SHALL shift b right, set p to p^b[0], and clear s. After bit DBIT-1 it SHALL enter parity; otherwise it SHALL increment n.
REQ-020 In parity, on s_tick with s==15, the FSM SHALL clear s and enter stop.
REQ-021 In stop, on s_tick with s==SB_TICK-1, the FSM SHALL pulse tx_done_tick for one clock and return to idle.
REQ-022 Cycles without s_tick SHALL leave s, n, b and the state unchanged.
REQ-023 tx SHALL be registered: 1 in idle and stop, 0 in start, b[0] in data, and the parity value in parity.
REQ-024 A write SHALL be accepted only when wr=1 and tx_full=0; a write while full SHALL be dropped with no state change.
REQ-025 On a simultaneous wr and pop while full, the write SHALL be rejected.
REQ-026 On a simultaneous wr and pop while not full, both SHALL occur.
REQ-027 Latency: with the FIFO empty and the FSM idle, tx SHALL fall at the second rising clk edge after wr is sampled.
REQ-028 Back-to-back frames SHALL have no idle gap: idle pops the next entry on the cycle after tx_done_tick.
REQ-029 FIFO read and write pointers SHALL wrap modulo 2^FIFO_W; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-030 On reset assertion, tx SHALL be 1, tx_done_tick 0, tx_full 0, state idle, and s, n, b, p and the FIFO pointers 0, immediately and asynchronously.
REQ-031 A reset mid-frame SHALL abort the frame: the line returns high and all FIFO contents are discarded.

Structure
REQ-032 State encodings (3-bit localparams) and the ticks-per-bit constant (16) SHALL reside in a shared uart package used by both the transmitter and the receiver.
REQ-033 The FIFO SHALL be a separate sub-module named uart_fifo, parameterised by data width and FIFO_W, with ports wr, rd, w_data, r_data, full and empty.

Verification
REQ-034 Write 0x55 with even parity: tx SHALL show 0,1,0,1,0,1,0,1,0, then parity 0, then 1, each bit 16 ticks, and one tx_done_tick.
REQ-035 Write 0x07 with even parity: parity bit SHALL be 1. With PARITY_ODD=1, the parity bit SHALL be 0.
REQ-036 Write 6 bytes on consecutive clocks with FIFO_W=2 and the FSM idle: 5 bytes SHALL be accepted and the 6th dropped. tx_full SHALL assert, and exactly 5 frames SHALL be sent back-to-back.
REQ-037 Assert reset during the data bits of a frame: tx SHALL go to 1 and no tx_done_tick SHALL occur. After release, with no writes, the line SHALL stay idle.
REQ-038 Loop tx into the team's uart_rx for bytes 0x00 to 0xFF: each received dout SHALL match the sent byte, and parityMatch SHALL remain 0.
